// File: rtl/maf_pkg.sv
// maf_pkg: shared types, window constants and averaging helper for the moving average filter
package maf_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LOG2_WIN = 3;
  localparam int WIN = 1 << DEF_LOG2_WIN;
  localparam int SUM_W = DEF_DATA_W + DEF_LOG2_WIN;
  typedef enum logic [1:0] {FILL, STEADY, CLEAR} state_e;
  function automatic logic [DEF_DATA_W-1:0] avg(input logic [SUM_W-1:0] s);
    return DEF_DATA_W'(s >> DEF_LOG2_WIN);
  endfunction
endpackage

// File: rtl/maf_delay_line.sv
// maf_delay_line: WIN-entry sample ring with one write port and a combinational read port
module maf_delay_line #(
  parameter int DATA_W = 8,
  parameter int LOG2_WIN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [LOG2_WIN-1:0] wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [LOG2_WIN-1:0] rd_idx,
  output logic [DATA_W-1:0]   rd_data
);
  localparam int NUM = 1 << LOG2_WIN;
  logic [DATA_W-1:0] mem_q [NUM];
  logic [DATA_W-1:0] mem_d [NUM];
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < NUM; i++) mem_q[i] <= '0;
    else mem_q <= mem_d;
  end
  assign rd_data = mem_q[rd_idx];
endmodule

// File: rtl/moving_average_filter.sv
// moving_average_filter: boxcar average over the last WIN samples using a ring buffer and running sum
module moving_average_filter import maf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LOG2_WIN = DEF_LOG2_WIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed
);
  state_e state_q, state_d;
  logic [LOG2_WIN-1:0] wr_ptr_q, wr_ptr_d, clr_idx_q, clr_idx_d, wr_idx;
  logic [LOG2_WIN:0] fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d, sum_acc;
  logic out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, rd_data, wr_data;
  logic accept, clr_done, fill_last, wr_en;
  maf_delay_line #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) u_line (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rd_idx(wr_ptr_q), .rd_data(rd_data)
  );
  always_comb begin
    in_ready = state_q != CLEAR;
    accept = in_valid && in_ready && !flush;
    fill_last = state_q == FILL && &fill_cnt_q[LOG2_WIN-1:0];
    clr_done = state_q == CLEAR && &clr_idx_q && !flush;
    // the entry being overwritten is the oldest sample, so it leaves the sum
    sum_acc = sum_q + SUM_W'(in_data) - SUM_W'(rd_data);
    state_d = flush ? CLEAR
            : state_q == CLEAR ? (clr_done ? FILL : CLEAR)
            : (accept && fill_last) ? STEADY : state_q;
    clr_idx_d = (flush || state_q != CLEAR) ? '0 : clr_idx_q + 1'b1;
    sum_d = clr_done ? '0 : accept ? sum_acc : sum_q;
    wr_ptr_d = clr_done ? '0 : accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    fill_cnt_d = clr_done ? '0 : (accept && state_q == FILL) ? fill_cnt_q + 1'b1 : fill_cnt_q;
    out_valid_d = accept && (state_q == STEADY || fill_last);
    out_data_d = out_valid_d ? avg(sum_acc) : out_data_q;
    wr_en = accept || state_q == CLEAR;
    wr_idx = state_q == CLEAR ? clr_idx_q : wr_ptr_q;
    wr_data = state_q == CLEAR ? '0 : in_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      wr_ptr_q <= '0;
      clr_idx_q <= '0;
      fill_cnt_q <= '0;
      sum_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      clr_idx_q <= clr_idx_d;
      fill_cnt_q <= fill_cnt_d;
      sum_q <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign primed = state_q == STEADY;
endmodule
